// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared widths, sentinels and helpers for the Tomasulo core (register file,
// ROB, reservation stations, LSB and dispatcher).
//   EX_REG_WIDTH-wide register indices carry one extra bit so that NON_REG
//   (1 << REG_WIDTH) can mean "no register".
//   EX_ROB_WIDTH-wide tags carry one extra bit so that NON_DEP
//   (1 << ROB_WIDTH) can mean "value is ready, no dependency".
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int EX_REG_WIDTH = 6;
  localparam int NUM_REGS     = 1 << REG_WIDTH;
  localparam int NON_REG      = 1 << REG_WIDTH;
  localparam int ROB_WIDTH    = 4;
  localparam int EX_ROB_WIDTH = 5;
  localparam int NON_DEP      = 1 << ROB_WIDTH;
  localparam int DATA_WIDTH   = 32;

  typedef logic [EX_REG_WIDTH-1:0] ex_reg_t;
  typedef logic [REG_WIDTH-1:0]    reg_idx_t;
  typedef logic [ROB_WIDTH-1:0]    rob_idx_t;
  typedef logic [EX_ROB_WIDTH-1:0] ex_rob_t;
  typedef logic [DATA_WIDTH-1:0]   word_t;

  localparam ex_reg_t NON_REG_IDX = ex_reg_t'(NON_REG);
  localparam ex_rob_t NON_DEP_TAG = ex_rob_t'(NON_DEP);
  localparam word_t   ZERO_WORD   = {DATA_WIDTH{1'b0}};

  // True when idx names a real, writable architectural register:
  // not x0 and not the NON_REG sentinel (nor anything above it).
  function automatic logic is_arch_reg(input ex_reg_t idx);
    return (idx[EX_REG_WIDTH-1] == 1'b0) && (idx[REG_WIDTH-1:0] != {REG_WIDTH{1'b0}});
  endfunction

  // A live rename tag is a ROB index with the sentinel bit cleared.
  function automatic ex_rob_t ext_tag(input rob_idx_t idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the architectural register file.
//   rs               in  source register index (NON_REG or 0 -> constant 0)
//   val_arr/tag_arr  in  current register values and rename tags
//   commit_*         in  ROB commit port, used for the same-cycle bypass
//   v                out value (meaningful when q == NON_DEP)
//   q                out rename tag, NON_DEP when the value is ready
// ---------------------------------------------------------------------------
module rf_read_port
  import reg_file_pkg::*;
(
  input  ex_reg_t  rs,
  input  word_t    val_arr [NUM_REGS],
  input  ex_rob_t  tag_arr [NUM_REGS],
  input  logic     commit_en,
  input  rob_idx_t commit_rob_index,
  input  ex_reg_t  commit_rd,
  input  word_t    commit_value,
  output word_t    v,
  output ex_rob_t  q
);

  reg_idx_t rs_idx_s;
  word_t    stored_val_s;
  ex_rob_t  stored_tag_s;
  logic     bypass_hit_s;

  // Look up the stored entry and detect a commit that resolves it this cycle.
  always_comb begin
    rs_idx_s     = rs[REG_WIDTH-1:0];
    stored_val_s = val_arr[rs_idx_s];
    stored_tag_s = tag_arr[rs_idx_s];
    // The commit only resolves this operand if the register still waits on
    // exactly the committing ROB entry; an older producer must not bypass.
    bypass_hit_s = commit_en
                && (commit_rd == rs)
                && (stored_tag_s == ext_tag(commit_rob_index));
  end

  // Select the operand: sentinel/x0 constant, bypassed commit, or stored entry.
  always_comb begin
    if (!is_arch_reg(rs)) begin
      v = ZERO_WORD;
      q = NON_DEP_TAG;
    end else if (bypass_hit_s) begin
      v = commit_value;
      q = NON_DEP_TAG;
    end else begin
      v = stored_val_s;
      q = stored_tag_s;
    end
  end

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Architectural register file with rename tags for the Tomasulo core.
//   Sys_clk / Sys_rst         clock, synchronous active-high reset
//   Sys_rdy                   low: hold all state, ignore requests
//   ROB2RF_*                  commit port from the reorder buffer; pre_judge
//                             is the mispredict flush that clears all tags
//   DP2RF_*                   dispatcher: rs1/rs2 operand reads, rd rename
//   RF2DP_Qj/Qk, Vj/Vk        operand tags and values (combinational)
// Reads always observe the pre-rename tag of the current cycle, so an
// instruction such as addi x1,x1,1 depends on the previous producer of x1.
// ---------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
(
  input  logic     Sys_clk,
  input  logic     Sys_rst,
  input  logic     Sys_rdy,
  input  logic     ROB2RF_pre_judge,
  input  logic     ROB2RF_en,
  input  rob_idx_t ROB2RF_ROB_index,
  input  ex_reg_t  ROB2RF_rd,
  input  word_t    ROB2RF_value,
  input  logic     DP2RF_en,
  input  ex_reg_t  DP2RF_rs1,
  input  ex_reg_t  DP2RF_rs2,
  input  ex_reg_t  DP2RF_rd,
  input  rob_idx_t DP2RF_ROB_index,
  output ex_rob_t  RF2DP_Qj,
  output ex_rob_t  RF2DP_Qk,
  output word_t    RF2DP_Vj,
  output word_t    RF2DP_Vk
);

  word_t    val_r     [NUM_REGS];
  ex_rob_t  tag_r     [NUM_REGS];
  word_t    val_nxt_s [NUM_REGS];
  ex_rob_t  tag_nxt_s [NUM_REGS];

  reg_idx_t commit_idx_s;
  reg_idx_t rename_idx_s;
  logic     commit_wr_s;
  logic     commit_clr_s;
  logic     rename_s;

  // Decode the commit and rename requests for this cycle.
  always_comb begin
    commit_idx_s = ROB2RF_rd[REG_WIDTH-1:0];
    rename_idx_s = DP2RF_rd[REG_WIDTH-1:0];
    commit_wr_s  = ROB2RF_en && is_arch_reg(ROB2RF_rd);
    // A flush wipes every speculative tag, so a rename in the same cycle
    // would only re-create a dependency on a squashed ROB entry.
    rename_s     = DP2RF_en && is_arch_reg(DP2RF_rd) && !ROB2RF_pre_judge;
    // Only the newest producer may clear the tag; a later rename of the
    // same register in this cycle keeps its fresh tag.
    commit_clr_s = commit_wr_s
                && (tag_r[commit_idx_s] == ext_tag(ROB2RF_ROB_index))
                && !(rename_s && (rename_idx_s == commit_idx_s));
  end

  // Next-state value and tag for every register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      // Committed values are architectural and land even during a flush.
      if (commit_wr_s && (commit_idx_s == REG_WIDTH'(i))) begin
        val_nxt_s[i] = ROB2RF_value;
      end else begin
        val_nxt_s[i] = val_r[i];
      end

      if (ROB2RF_pre_judge) begin
        tag_nxt_s[i] = NON_DEP_TAG;
      end else if (rename_s && (rename_idx_s == REG_WIDTH'(i))) begin
        tag_nxt_s[i] = ext_tag(DP2RF_ROB_index);
      end else if (commit_clr_s && (commit_idx_s == REG_WIDTH'(i))) begin
        tag_nxt_s[i] = NON_DEP_TAG;
      end else begin
        tag_nxt_s[i] = tag_r[i];
      end
    end
  end

  // State register: reset dominates, Sys_rdy low freezes everything.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_r[i] <= ZERO_WORD;
        tag_r[i] <= NON_DEP_TAG;
      end
    end else if (Sys_rdy) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_r[i] <= val_nxt_s[i];
        tag_r[i] <= tag_nxt_s[i];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_r[i] <= val_r[i];
        tag_r[i] <= tag_r[i];
      end
    end
  end

  // Operand j (rs1).
  rf_read_port u_read_j (
    .rs               (DP2RF_rs1),
    .val_arr          (val_r),
    .tag_arr          (tag_r),
    .commit_en        (ROB2RF_en),
    .commit_rob_index (ROB2RF_ROB_index),
    .commit_rd        (ROB2RF_rd),
    .commit_value     (ROB2RF_value),
    .v                (RF2DP_Vj),
    .q                (RF2DP_Qj)
  );

  // Operand k (rs2).
  rf_read_port u_read_k (
    .rs               (DP2RF_rs2),
    .val_arr          (val_r),
    .tag_arr          (tag_r),
    .commit_en        (ROB2RF_en),
    .commit_rob_index (ROB2RF_ROB_index),
    .commit_rd        (ROB2RF_rd),
    .commit_value     (ROB2RF_value),
    .v                (RF2DP_Vk),
    .q                (RF2DP_Qk)
  );

endmodule
